// File: rtl/vfifo_pkg.sv
// Shared constants and helpers for the vfifo controller family.
// Pointer width is always one bit wider than the RAM address.
package vfifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_PTR_WIDTH  = DEFAULT_ADDR_WIDTH + 1;

  // Registered status flags, grouped so they move together.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } status_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/vfifo_ptr_cnt.sv
// Enabled wrapping pointer counter with synchronous active-high reset.
// It wraps modulo 2^WIDTH.
module vfifo_ptr_cnt
  import vfifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_PTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vfifo_sync_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with registered read.
// Optional macro VFIFO_LEVEL_EN adds a registered fill counter and the level port.
module vfifo_sync_ctrl
  import vfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_LVL  = 2**ADDR_WIDTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] adr_a,
  output logic [ADDR_WIDTH-1:0] adr_b,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic                  ovf,
  output logic                  udf
`ifdef VFIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH      = PTR_W'(2**ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AFULL_THR  = PTR_W'(AFULL_LVL);
  localparam logic [PTR_W-1:0] AEMPTY_THR = PTR_W'(AEMPTY_LVL);

  logic             push_ok;
  logic             pop_ok;
  logic [1:0]       ptr_en;
  logic [PTR_W-1:0] ptrs [2];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fill_next;
  status_t          status_next;

  // A full FIFO still accepts a pop and an empty one still accepts a push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign ptr_en  = {pop_ok, push_ok};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ptr
      vfifo_ptr_cnt #(
        .WIDTH(PTR_W)
      ) u_ptr_cnt (
        .clk(clk),
        .rst(rst),
        .en (ptr_en[gi]),
        .cnt(ptrs[gi])
      );
    end
  endgenerate

  assign wr_ptr = ptrs[0];
  assign rd_ptr = ptrs[1];
  assign we_a   = push_ok;
  assign adr_a  = wr_ptr[ADDR_WIDTH-1:0];
  assign adr_b  = rd_ptr[ADDR_WIDTH-1:0];

`ifdef VFIFO_LEVEL_EN
  logic [PTR_W-1:0] level_reg;

  always_comb begin
    fill_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   fill_next = level_reg + PTR_W'(1);
      2'b01:   fill_next = level_reg - PTR_W'(1);
      default: fill_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else begin
      level_reg <= fill_next;
    end
  end

  assign level = level_reg;
`else
  // Modulo pointer difference of the post-edge pointers is the next fill level.
  assign fill_next = (wr_ptr + {{ADDR_WIDTH{1'b0}}, push_ok})
                   - (rd_ptr + {{ADDR_WIDTH{1'b0}}, pop_ok});
`endif

  always_comb begin
    status_next.full   = (fill_next == DEPTH);
    status_next.empty  = (fill_next == '0);
    status_next.afull  = (fill_next >= AFULL_THR);
    status_next.aempty = (fill_next <= AEMPTY_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      aempty   <= 1'b1;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      full     <= status_next.full;
      empty    <= status_next.empty;
      afull    <= status_next.afull;
      aempty   <= status_next.aempty;
      rd_valid <= pop_ok;
      if (push && full) begin
        ovf <= 1'b1;
      end
      if (pop && empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vfifo_sync_ctrl.sv
// Self-checking bench for vfifo_sync_ctrl: vector table plus directed corner sequences.
// A behavioural RAM with registered read stands in for the external memory.
module tb_vfifo_sync_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic          we_a;
  logic [AW-1:0] adr_a;
  logic [AW-1:0] adr_b;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic          ovf;
  logic          udf;
`ifdef VFIFO_LEVEL_EN
  logic [AW:0]   level;
`endif

  logic [7:0] din;
  logic [7:0] q_b;
  logic [7:0] mem [DEPTH];

  int checks;
  int errors;
  int mlev;
  logic [7:0] sb [$];
  logic we_seen;

  vfifo_sync_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .we_a    (we_a),
    .adr_a   (adr_a),
    .adr_b   (adr_b),
    .rd_valid(rd_valid),
    .full    (full),
    .empty   (empty),
    .afull   (afull),
    .aempty  (aempty),
    .ovf     (ovf),
    .udf     (udf)
`ifdef VFIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_a) mem[adr_a] <= din;
    q_b <= mem[adr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample we_a before the edge, then check
  // rd_valid / popped data against the scoreboard 1 unit after the edge.
  task automatic cyc(input logic r, input logic p, input logic q, input logic [7:0] d,
                     output logic we_pre);
    logic push_acc;
    logic pop_acc;
    logic [7:0] exp_d;
    @(negedge clk);
    rst = r; push = p; pop = q; din = d;
    #1 we_pre = we_a;
    push_acc = p && (mlev != DEPTH);
    pop_acc  = q && (mlev != 0);
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      mlev = 0;
      chk("rd_valid_rst", {31'd0, rd_valid}, 32'd0);
    end else begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, pop_acc});
      if (pop_acc) begin
        exp_d = sb.pop_front();
        chk("rd_data", {24'd0, q_b}, {24'd0, exp_d});
      end
      if (push_acc) sb.push_back(d);
      mlev = mlev + int'(push_acc) - int'(pop_acc);
    end
`ifdef VFIFO_LEVEL_EN
    chk("level", {27'd0, level}, mlev);
`endif
    $display("cyc rst=%0b push=%0b pop=%0b we_a=%0b full=%0b empty=%0b afull=%0b aempty=%0b ovf=%0b udf=%0b rv=%0b a=%0d b=%0d",
             r, p, q, we_pre, full, empty, afull, aempty, ovf, udf, rd_valid, adr_a, adr_b);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, {25'd0, full, empty, afull, aempty, ovf, udf, rd_valid}, 32'b0101000);
    chk({tag, "_adr_a"}, {28'd0, adr_a}, 32'd0);
    chk({tag, "_adr_b"}, {28'd0, adr_b}, 32'd0);
  endtask

  typedef struct {
    logic       r;
    logic       p;
    logic       q;
    logic       we;
    logic [6:0] flags;  // full empty afull aempty ovf udf rd_valid
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  vec_t vecs [12];

  initial begin
    checks = 0;
    errors = 0;
    mlev = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b0101000, 4'd0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0001000, 4'd1, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0001000, 4'd2, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'b0000000, 4'd3, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b0000001, 4'd4, 4'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0001001, 4'd4, 4'd2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000, 4'd4, 4'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0001001, 4'd4, 4'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0101001, 4'd4, 4'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0101010, 4'd4, 4'd4};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b0001010, 4'd5, 4'd4};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 7'b0101000, 4'd0, 4'd0};

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].r, vecs[i].p, vecs[i].q, 8'(8'h10 + i), we_seen);
      chk($sformatf("vec%0d_we_a", i), {31'd0, we_seen}, {31'd0, vecs[i].we});
      chk($sformatf("vec%0d_flags", i),
          {25'd0, full, empty, afull, aempty, ovf, udf, rd_valid}, {25'd0, vecs[i].flags});
      chk($sformatf("vec%0d_adr_a", i), {28'd0, adr_a}, {28'd0, vecs[i].a});
      chk($sformatf("vec%0d_adr_b", i), {28'd0, adr_b}, {28'd0, vecs[i].b});
    end

    // Fill to full: afull from the 14th push, full only on the 16th.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, we_seen);
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(8'h40 + k), we_seen);
      chk($sformatf("fill%0d_afull", k), {31'd0, afull}, {31'd0, (k >= 14)});
      chk($sformatf("fill%0d_full", k), {31'd0, full}, {31'd0, (k == 16)});
    end
    chk("fill_ovf", {31'd0, ovf}, 32'd0);

    // 17th push while full: rejected, ovf sticks, write pointer holds.
    cyc(1'b0, 1'b1, 1'b0, 8'hEE, we_seen);
    chk("ovf_we_a", {31'd0, we_seen}, 32'd0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("ovf_adr_a", {28'd0, adr_a}, 32'd0);
    chk("ovf_full", {31'd0, full}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, we_seen);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);
    // Full with push and pop together: pop wins, push ignored.
    cyc(1'b0, 1'b1, 1'b1, 8'hEF, we_seen);
    chk("fullpp_we_a", {31'd0, we_seen}, 32'd0);
    chk("fullpp_full", {31'd0, full}, 32'd0);
    chk("fullpp_adr_b", {28'd0, adr_b}, 32'd1);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b1, 8'h00, we_seen);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_ovf", {31'd0, ovf}, 32'd1);

    // Push 0xA5 then pop on the next cycle.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, we_seen);
    cyc(1'b0, 1'b1, 1'b0, 8'hA5, we_seen);
    chk("a5_empty", {31'd0, empty}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00, we_seen);
    chk("a5_q_b", {24'd0, q_b}, 32'hA5);
    chk("a5_rd_valid", {31'd0, rd_valid}, 32'd1);

    // Level 5, then 40 cycles of simultaneous push/pop.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, we_seen);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h60 + k), we_seen);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 8'(8'h80 + k), we_seen);
      chk($sformatf("stream%0d_flags", k), {28'd0, full, empty, afull, aempty}, 32'b0000);
    end
    chk("stream_adr_a", {28'd0, adr_a}, 32'd13);
    chk("stream_adr_b", {28'd0, adr_b}, 32'd8);
    chk("stream_level", mlev, 32'd5);

    // Empty with push and pop together: push wins, udf set.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, we_seen);
    cyc(1'b0, 1'b1, 1'b1, 8'hC3, we_seen);
    chk("udf_set", {31'd0, udf}, 32'd1);
    chk("udf_empty", {31'd0, empty}, 32'd0);
    chk("udf_adr_a", {28'd0, adr_a}, 32'd1);
    chk("udf_adr_b", {28'd0, adr_b}, 32'd0);

    // Reset mid-stream at level 9 with push and pop active.
    cyc(1'b1, 1'b0, 1'b0, 8'h00, we_seen);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 1'b0, 8'(8'hD0 + k), we_seen);
    chk("lvl9_adr_a", {28'd0, adr_a}, 32'd9);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF, we_seen);
    chk_reset_state("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vfifo_sync_ctrl.md
VFIFO_SYNC_CTRL -- requirements
Module: vfifo_sync_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; depth = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter AFULL_LVL, default 2^ADDR_WIDTH-2, fill level at or above which afull asserts.
REQ-003 SHALL have parameter AEMPTY_LVL, default 2, fill level at or below which aempty asserts.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have push  in  1  write request.
REQ-006 SHALL have pop  in  1  read request.
REQ-007 SHALL have we_a  out  1  RAM write enable, combinational = push & ~full.
REQ-008 SHALL have adr_a  out  ADDR_WIDTH  RAM write address = write pointer low bits.
REQ-009 SHALL have adr_b  out  ADDR_WIDTH  RAM read address = read pointer low bits.
REQ-010 SHALL have rd_valid  out  1  RAM q_b holds popped word this cycle.
REQ-011 SHALL have full, empty, afull, aempty  out  1 each  registered status flags.
REQ-012 SHALL have ovf, udf  out  1 each  sticky overflow/underflow error flags.
REQ-013 SHALL have level  out  ADDR_WIDTH+1  fill count (only when VFIFO_LEVEL_EN defined).

Function
REQ-014 SHALL keep write and read pointers of ADDR_WIDTH+1 bits; extra MSB distinguishes full from empty on wrap.
REQ-015 SHALL accept a push only when full=0; accepted push increments write pointer at the clock edge.
REQ-016 SHALL accept a pop only when empty=0; accepted pop increments read pointer at the clock edge.
REQ-017 SHALL drive adr_b from the current read pointer so the RAM's registered read address captures it on the pop edge; rd_valid SHALL be registered = accepted pop, making q_b valid exactly 1 cycle after pop.
REQ-018 SHALL, on simultaneous accepted push and pop, keep fill level unchanged and move both pointers.
REQ-019 SHALL, with full=1 and push=pop=1, accept pop, ignore push, set ovf.
REQ-020 SHALL, with empty=1 and push=pop=1, accept push, ignore pop, set udf.
REQ-021 SHALL set ovf on any push while full=1 and udf on any pop while empty=1; both stay set until reset.
REQ-022 SHALL compute full/empty/afull/aempty from next-state fill level so flags are valid in the cycle after the causing edge.
REQ-023 SHALL wrap pointers modulo 2^(ADDR_WIDTH+1) with no special handling.
REQ-024 SHALL guarantee a word written at edge N is poppable at edge N+1 (empty deasserts after edge N).

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear both pointers, level=0, empty=1, aempty=1, full=0, afull=0, rd_valid=0, ovf=0, udf=0.
REQ-026 SHALL give rst priority over push/pop in the same cycle; contents in flight are discarded.

Configuration
REQ-027 SHALL compile a registered fill-level counter and the level port only when macro VFIFO_LEVEL_EN is defined.
REQ-028 SHALL, without VFIFO_LEVEL_EN, derive flags from pointer difference, omit the level port, and keep all other behaviour identical.

Structure
REQ-029 SHALL place the default ADDR_WIDTH and the pointer-width constant (ADDR_WIDTH+1) in shared package vfifo_pkg.
REQ-030 SHALL instantiate sub-module vfifo_ptr_cnt (enabled wrapping ADDR_WIDTH+1-bit counter with synchronous reset) twice, for write and read pointers.

Verification
REQ-031 SHALL cover: reset, then 16 pushes (ADDR_WIDTH=4) -> full=1 after 16th edge, afull=1 after 14th, level=16, ovf=0.
REQ-032 SHALL cover: 17th push while full -> ovf=1 sticky, write pointer unchanged, we_a=0.
REQ-033 SHALL cover: push 0xA5 then pop next cycle -> rd_valid=1 and q_b=0xA5 one cycle after pop.
REQ-034 SHALL cover: 40 cycles simultaneous push/pop at level 5 -> level stays 5, pointers wrap twice, data order preserved.
REQ-035 SHALL cover: pop on empty with push=1 -> udf=1, level=1, empty=0 next cycle.
REQ-036 SHALL cover: rst asserted at level 9 mid-stream -> all outputs at REQ-025 values next cycle.
